// File: rtl/uart_pkg.sv
// uart_pkg: shared types and frame constants for the UART transmit path.
//   tx_state_t : transmitter FSM states
//   FRAME_BITS : start + 8 data + stop
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam int   FRAME_BITS = 10;
   localparam int   DATA_BITS  = 8;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/flex_pts_sr.sv
// flex_pts_sr: parallel-load / serial-out shift register, idle-level fill.
//   clk, n_rst    : clock, async active-low reset (register resets to all ones)
//   load_enable   : capture parallel_in (wins over shift_enable)
//   shift_enable  : shift one position toward the output end
//   parallel_in   : NUM_BITS word to load
//   serial_out    : MSB when SHIFT_MSB=1, LSB otherwise
module flex_pts_sr
   import uart_pkg::*;
#(
   parameter int NUM_BITS  = 4,
   parameter bit SHIFT_MSB = 1'b1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                shift_enable,
   input  logic                load_enable,
   input  logic [NUM_BITS-1:0] parallel_in,
   output logic                serial_out
);
   logic [NUM_BITS-1:0] q;
   logic [NUM_BITS-1:0] q_shift;

   // Vacated positions fill with the idle level so an emptied register
   // naturally holds the line high.
   generate
      if (SHIFT_MSB) begin : g_msb
         assign q_shift    = {q[NUM_BITS-2:0], IDLE_LEVEL};
         assign serial_out = q[NUM_BITS-1];
      end else begin : g_lsb
         assign q_shift    = {IDLE_LEVEL, q[NUM_BITS-1:1]};
         assign serial_out = q[0];
      end
   endgenerate

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)            q <= '1;
      else if (load_enable)  q <= parallel_in;
      else if (shift_enable) q <= q_shift;
   end
endmodule

// File: rtl/uart_tx_block.sv
// uart_tx_block: 8N1 UART transmitter, BIT_PERIOD clocks per bit.
//   clk, n_rst : clock, async active-low reset
//   tx_start   : send request, only honoured in IDLE
//   tx_data    : byte captured when tx_start is accepted
//   serial_out : registered line (shifter LSB), idles high
//   tx_busy    : high for the whole 10*BIT_PERIOD frame
//   tx_done    : one-cycle pulse in the first IDLE cycle after the stop bit
module uart_tx_block
   import uart_pkg::*;
#(
   parameter int BIT_PERIOD = 10
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       serial_out,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int             TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam logic [TW-1:0]  TC = TW'(BIT_PERIOD - 1);
   localparam int             BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);

   tx_state_t     state;
   logic [TW-1:0] timer;
   logic [BW-1:0] bit_cnt;
   logic          load;
   logic          tick;

   // Acceptance is decided purely by state, so a strobe during a frame can
   // never reach the shifter.
   assign load = (state == IDLE) && tx_start;
   assign tick = (state != IDLE) && (timer == TC);

   flex_pts_sr #(
      .NUM_BITS  (FRAME_BITS),
      .SHIFT_MSB (1'b0)
   ) u_sr (
      .clk          (clk),
      .n_rst        (n_rst),
      .shift_enable (tick),
      .load_enable  (load),
      .parallel_in  ({STOP_BIT, tx_data, START_BIT}),
      .serial_out   (serial_out)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         timer   <= '0;
         bit_cnt <= '0;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (state == IDLE) begin
            if (tx_start) begin
               state   <= START;
               timer   <= '0;
               bit_cnt <= '0;
               tx_busy <= 1'b1;
            end
         end else if (tick) begin
            timer <= '0;
            case (state)
               START: state <= DATA;
               DATA: begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) state <= STOP;
               end
               STOP: begin
                  // busy drops in the same cycle done rises; a tx_start seen
                  // in that cycle is accepted for a 1-cycle inter-frame gap.
                  state   <= IDLE;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_block.sv
// tb_uart_tx_block: three DUTs (BIT_PERIOD 10, 2, 16) on one clock.
// Frames are pushed to a scoreboard when sent and popped when the line
// shows a start bit. Inputs change and outputs are sampled on negedge.
module tb_uart_tx_block;
   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic [2:0] start;
   logic [7:0] data [3];
   logic [2:0] ser;
   logic [2:0] busy;
   logic [2:0] done;

   int         bp_of [3] = '{10, 2, 16};
   logic [9:0] exp_q [$];
   int         passed = 0;
   int         total  = 0;

   always #5 clk = ~clk;

   uart_tx_block #(.BIT_PERIOD(10)) u_bp10 (
      .clk(clk), .n_rst(n_rst), .tx_start(start[0]), .tx_data(data[0]),
      .serial_out(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
   uart_tx_block #(.BIT_PERIOD(2)) u_bp2 (
      .clk(clk), .n_rst(n_rst), .tx_start(start[1]), .tx_data(data[1]),
      .serial_out(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
   uart_tx_block #(.BIT_PERIOD(16)) u_bp16 (
      .clk(clk), .n_rst(n_rst), .tx_start(start[2]), .tx_data(data[2]),
      .serial_out(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));

   // Strobe a byte now (caller sits just after a negedge) and log its frame.
   task automatic send(input int d, input logic [7:0] b);
      data[d]  = b;
      start[d] = 1'b1;
      exp_q.push_back({1'b1, b, 1'b0});
   endtask

   // Wait up to budget negedges for the start bit, then check each frame bit
   // holds for exactly BIT_PERIOD samples, busy throughout, and the done cycle.
   task automatic expect_frame(input int d, input int budget, input bit clr);
      int         bp = bp_of[d];
      bit         found = 0;
      bit         ok;
      int         bad = 0;
      logic [9:0] f;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (clr && i == 0) start[d] = 1'b0;
         if (ser[d] === 1'b0) found = 1;
      end
      total++;
      if (!found || exp_q.size() == 0) begin
         $display("FAIL start_bit dut%0d: line %b, want 0 within %0d cycles, queued %0d",
                  d, ser[d], budget, exp_q.size());
         if (exp_q.size() != 0) f = exp_q.pop_front();
      end else begin
         passed++;
         f = exp_q.pop_front();
         for (int k = 0; k < 10; k++) begin
            ok = 1;
            for (int s = 0; s < bp; s++) begin
               if (!(k == 0 && s == 0)) @(negedge clk);
               if (ser[d] !== f[k]) ok = 0;
               if (busy[d] !== 1'b1 || done[d] !== 1'b0) bad++;
            end
            total++;
            if (!ok) $display("FAIL bit%0d dut%0d: line not held at %b for %0d cycles (now %b)",
                              k, d, f[k], bp, ser[d]);
            else passed++;
         end
         total++;
         if (bad != 0) $display("FAIL busy_window dut%0d: %0d bad busy/done samples, want 0 over %0d",
                                d, bad, 10 * bp);
         else passed++;
         @(negedge clk);
         total++;
         if (done[d] !== 1'b1 || busy[d] !== 1'b0 || ser[d] !== 1'b1)
            $display("FAIL done_cycle dut%0d: done=%b busy=%b line=%b, want 1 0 1",
                     d, done[d], busy[d], ser[d]);
         else passed++;
      end
   endtask

   task automatic check_idle(input int d, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (ser[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0) bad++;
      end
      total++;
      if (bad != 0) $display("FAIL idle dut%0d: %0d non-idle samples, want 0 of %0d", d, bad, n);
      else passed++;
   endtask

   task automatic test_reset();
      int bad = 0;
      #1 n_rst = 1'b0;
      #1;
      total++;
      if (ser !== 3'b111 || busy !== 3'b000 || done !== 3'b000)
         $display("FAIL async_reset: line=%b busy=%b done=%b, want 111 000 000", ser, busy, done);
      else passed++;
      repeat (8) begin
         @(negedge clk);
         start = 3'($urandom);
         for (int d = 0; d < 3; d++) data[d] = 8'($urandom);
         if (ser !== 3'b111 || busy !== 3'b000 || done !== 3'b000) bad++;
      end
      total++;
      if (bad != 0) $display("FAIL reset_hold: %0d bad samples, want 0", bad);
      else passed++;
      @(negedge clk);
      start = 3'b000;
      n_rst = 1'b1;
      for (int d = 0; d < 3; d++) check_idle(d, 1);
      check_idle(0, 3);
   endtask

   task automatic test_single_frame();
      send(0, 8'hA5);
      expect_frame(0, 1, 1'b1);
      check_idle(0, 5);
   endtask

   task automatic test_busy_ignore();
      send(0, 8'h3C);
      fork
         expect_frame(0, 1, 1'b1);
         begin
            repeat (5) @(negedge clk);
            data[0] = 8'hFF; start[0] = 1'b1;
            @(negedge clk) start[0] = 1'b0;
            repeat (44) @(negedge clk);
            start[0] = 1'b1;
            @(negedge clk) start[0] = 1'b0;
            repeat (44) @(negedge clk);
            start[0] = 1'b1;
            @(negedge clk) start[0] = 1'b0;
         end
      join
      check_idle(0, 20);
   endtask

   task automatic test_back_to_back();
      send(0, 8'h00);
      expect_frame(0, 1, 1'b0);
      // Still holding tx_start in the done cycle: new byte goes in now.
      data[0] = 8'hFF;
      exp_q.push_back({1'b1, 8'hFF, 1'b0});
      expect_frame(0, 1, 1'b1);
      check_idle(0, 5);
   endtask

   task automatic test_reset_mid_frame();
      data[0]  = 8'h55;
      start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      repeat (42) @(negedge clk);
      total++;
      if (ser[0] !== 1'b0) $display("FAIL pre_reset_line: line=%b, want 0", ser[0]);
      else passed++;
      #2 n_rst = 1'b0;
      #1;
      total++;
      if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0)
         $display("FAIL mid_reset: line=%b busy=%b done=%b, want 1 0 0", ser[0], busy[0], done[0]);
      else passed++;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      check_idle(0, 12);
      send(0, 8'h81);
      expect_frame(0, 1, 1'b1);
      check_idle(0, 3);
   endtask

   task automatic test_param_sweep();
      for (int d = 1; d < 3; d++) begin
         send(d, 8'hC3);
         expect_frame(d, 1, 1'b1);
         check_idle(d, 4);
      end
   endtask

   initial begin
      start = 3'b000;
      for (int d = 0; d < 3; d++) data[d] = 8'h00;
      test_reset();
      test_single_frame();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_frame();
      test_param_sweep();
      total++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d frames left, want 0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
